// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DATA_BITS = 8;

  // Width of a cycle counter that must reach cpb-1.
  function automatic int cnt_width(input int cpb);
    return (cpb > 2) ? $clog2(cpb) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_byte_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs, reset to RST_VAL.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: mid-bit sampling, start-glitch rejection, framing-error pulse.
//   state | meaning
//   IDLE  | waiting for a falling edge on the synchronized line
//   START | timing to the start-bit centre to confirm it is still low
//   DATA  | sampling 8 data bits at bit centres, LSB first
//   STOP  | sampling the stop bit; publish byte or flag framing error
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam int CW       = cnt_width(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_CNT = CW'(HALF_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

  logic                 w_rx_s;
  logic                 r_rx_prev;
  state_t               r_state;
  state_t               w_next_state;
  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_data_valid;
  logic                 r_frame_err;

  logic w_start_edge;
  logic w_half_tick;
  logic w_bit_tick;
  logic w_last_bit;
  logic w_busy;
  logic w_shift_en;
  logic w_accept;
  logic w_reject;
  logic w_cnt_clr;

  sync2 #(.RST_VAL(1'b1)) u_sync_rx (
    .clk (clk),
    .rst (rst),
    .i_d (rx_in),
    .o_q (w_rx_s)
  );

  assign w_start_edge = r_rx_prev & ~w_rx_s;
  assign w_half_tick  = (r_cnt == HALF_CNT);
  assign w_bit_tick   = (r_cnt == LAST_CNT);
  assign w_last_bit   = (r_bit_idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // A held-low line leaves rx_prev low, so a break cannot retrigger START.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (w_start_edge) w_next_state = START;
      START: if (w_half_tick)  w_next_state = w_rx_s ? IDLE : DATA;
      DATA:  if (w_bit_tick && w_last_bit) w_next_state = STOP;
      STOP:  if (w_bit_tick)   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_busy     = (r_state != IDLE);
    w_shift_en = (r_state == DATA) && w_bit_tick;
    w_accept   = (r_state == STOP) && w_bit_tick && w_rx_s;
    w_reject   = (r_state == STOP) && w_bit_tick && !w_rx_s;
    // Wrap at each bit boundary too, since CLKS_PER_BIT need not be a power of two.
    w_cnt_clr  = (w_next_state != r_state) || (r_state == IDLE) || w_shift_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_prev <= 1'b1;
      r_cnt     <= '0;
    end else begin
      r_rx_prev <= w_rx_s;
      if (w_cnt_clr) r_cnt <= '0;
      else           r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if (r_state == START) begin
        r_bit_idx <= '0;
      end else if (w_shift_en) begin
        r_bit_idx <= r_bit_idx + 1'b1;
        r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_data_valid <= w_accept;
      r_frame_err  <= w_reject;
      if (w_accept) r_data_out <= r_shift;
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign busy       = w_busy;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte at 16 clocks per bit, with a byte-assembler model downstream.
module tb_uart_rx_byte;

  localparam int CPB = 16;
  localparam int LAT = 155;  // negedge drive of start bit to visible pulse, incl. 2-flop sync

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         at_cyc;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         n_pulses = 0;
  int         asm_done = 0;
  int         asm_cnt = 0;
  logic       asm_en = 1'b0;
  logic [63:0] asm_sr = '0;
  logic [7:0] last_good = 8'h00;
  logic       prev_pulse = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops scoreboard on every output pulse and feeds the byte assembler.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      prev_pulse = 1'b0;
      asm_cnt    = 0;
    end else begin
      if (data_valid && frame_err)
        check("pulse_exclusive", 64'({data_valid, frame_err}), 64'b10);
      if ((data_valid || frame_err) && prev_pulse)
        check("pulse_single_cycle", 64'(prev_pulse), 64'b0);
      if (data_valid || frame_err) begin
        n_pulses++;
        if (q.size() == 0) begin
          check("unexpected_pulse", 64'({data_valid, frame_err}), 64'b00);
        end else begin
          e = q.pop_front();
          check("pulse_kind", 64'({data_valid, frame_err}), e.is_err ? 64'b01 : 64'b10);
          check("data_out", 64'(data_out), 64'(e.data));
          check("pulse_time", 64'(cyc), 64'(e.at_cyc));
        end
      end
      if (data_valid && asm_en) begin
        asm_sr = {asm_sr[55:0], data_out};
        asm_cnt++;
        if (asm_cnt == 8) begin
          check("asm_A", 64'(asm_sr[63:32]), 64'h3F800000);
          check("asm_B", 64'(asm_sr[31:0]),  64'h40000000);
          asm_done++;
          asm_cnt = 0;
        end
      end
      prev_pulse = data_valid || frame_err;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    exp_t e;
    e.is_err = !stop_bit;
    e.data   = stop_bit ? b : last_good;
    e.at_cyc = cyc + LAT;
    q.push_back(e);
    if (stop_bit) last_good = b;
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_in = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 300 && q.size() != 0; k++) @(negedge clk);
    check(name, 64'(q.size()), 64'd0);
  endtask

  initial begin
    int p0;
    logic [7:0] v6 [8];
    v6 = '{8'h3F, 8'h80, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_data_out", 64'(data_out), 64'h00);
    check("rst_valid", 64'(data_valid), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // 1: single frame 0xA5
    send_byte(8'hA5, 1'b1);
    repeat (2) @(negedge clk);
    check("t1_busy_after", 64'(busy), 64'd0);
    drain("t1_drain");

    // 2: back-to-back with zero gap
    send_byte(8'h3C, 1'b1);
    send_byte(8'hC3, 1'b1);
    repeat (5) @(negedge clk);
    drain("t2_drain");

    // 3: short start glitch
    repeat (10) @(negedge clk);
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    rx_in = 1'b1;
    @(negedge clk);
    check("t3_busy_during", 64'(busy), 64'd1);
    repeat (10) @(negedge clk);
    check("t3_busy_after", 64'(busy), 64'd0);
    check("t3_data_held", 64'(data_out), 64'hC3);
    repeat (10) @(negedge clk);

    // 4: framing error, break, then a good frame
    send_byte(8'h55, 1'b0);
    repeat (40) @(negedge clk);
    check("t4_break_idle", 64'(busy), 64'd0);
    rx_in = 1'b1;
    repeat (20) @(negedge clk);
    check("t4_data_held", 64'(data_out), 64'hC3);
    send_byte(8'h12, 1'b1);
    repeat (5) @(negedge clk);
    drain("t4_drain");

    // 5: async reset in the middle of data bit 4 of 0x81
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_in = (i == 0) ? 1'b1 : 1'b0;
      repeat (CPB) @(negedge clk);
    end
    rx_in = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    check("t5_busy_mid_frame", 64'(busy), 64'd1);
    #1;
    rst = 1'b1;
    rx_in = 1'b1;
    #1;
    check("t5_rst_data_out", 64'(data_out), 64'h00);
    check("t5_rst_valid", 64'(data_valid), 64'd0);
    check("t5_rst_frame_err", 64'(frame_err), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send_byte(8'hFF, 1'b1);
    repeat (5) @(negedge clk);
    drain("t5_drain");

    // 6: eight bytes into the assembler
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    asm_en = 1'b1;
    repeat (5) @(negedge clk);
    p0 = n_pulses;
    for (int i = 0; i < 8; i++) send_byte(v6[i], 1'b1);
    repeat (5) @(negedge clk);
    drain("t6_drain");
    check("t6_pulse_count", 64'(n_pulses - p0), 64'd8);
    check("t6_asm_done", 64'(asm_done), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
